servo_pwm_driver: RTL and testbench

Three-channel servo pulse generator that turns the 20-bit pulse-width constants from the angle decoder (`x_value`, `y_value`, `fire_value`) into the actual servo control waveforms. It sits between the angle decoder and the servo pins, one frame counter shared by all channels.

Inputs are sampled only at frame boundaries, so a pulse is never glitched mid-frame. The X and Y channels are slew-limited so a jump in commanded width is spread over several frames. The fire channel always snaps to its new value.

---
 rtl/servo_pkg.sv | 26 ++
 rtl/servo_slew_ch.sv | 73 +++++++
 rtl/servo_pwm_driver.sv | 121 ++++++++++++
 tb/tb_servo_pwm_driver.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo constants: pulse-width type, default timing and named widths.
// Used by the angle decoder and the servo PWM driver.
package servo_pkg;

    localparam int SERVO_W    = 20;
    localparam int DEF_PERIOD = 1_000_000;
    localparam int DEF_SLEW   = 5000;

    localparam logic [SERVO_W-1:0] W_RIGHT   = 20'd15000;
    localparam logic [SERVO_W-1:0] W_LEFT    = 20'd60000;
    localparam logic [SERVO_W-1:0] W_HOLD    = 20'd70000;
    localparam logic [SERVO_W-1:0] W_RELEASE = 20'd75000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [SERVO_W-1:0] clamp_w(
        input logic [SERVO_W-1:0] v,
        input logic [SERVO_W-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: boundary-latched, optionally slew-limited active width
// and a registered pulse output aligned to the shared frame counter.
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD,
    parameter int SLEW_STEP     = DEF_SLEW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_bnd,
    input  logic               i_run,
    input  logic [SERVO_W-1:0] i_target,
    input  logic               i_primed,
    input  logic               i_slew_en,
    input  logic [SERVO_W-1:0] i_cnt,
    output logic [SERVO_W-1:0] o_active,
    output logic               o_pwm
);

    localparam logic [SERVO_W-1:0] PER    = SERVO_W'(PERIOD_CYCLES);
    localparam logic [SERVO_W:0]   STEP21 = 21'(SLEW_STEP);

    logic [SERVO_W-1:0] r_active;
    logic               r_pwm;

    logic [SERVO_W-1:0] w_tgt;
    logic [SERVO_W:0]   w_t21;
    logic [SERVO_W:0]   w_a21;
    logic [SERVO_W:0]   w_diff;
    logic [SERVO_W:0]   w_up;
    logic [SERVO_W:0]   w_dn;
    logic [SERVO_W:0]   w_cnt_inc;
    logic [SERVO_W-1:0] w_new;

    assign w_tgt     = clamp_w(i_target, PER);
    assign w_t21     = {1'b0, w_tgt};
    assign w_a21     = {1'b0, r_active};
    assign w_up      = w_a21 + STEP21;
    assign w_dn      = w_a21 - STEP21;
    assign w_cnt_inc = {1'b0, i_cnt} + 21'd1;

    // Unsigned 21-bit distance; each branch only subtracts the smaller value.
    always_comb begin
        w_new  = w_tgt;
        w_diff = '0;
        if (i_primed && i_slew_en && (STEP21 != '0)) begin
            if (w_t21 >= w_a21) begin
                w_diff = w_t21 - w_a21;
                if (w_diff > STEP21) w_new = w_up[SERVO_W-1:0];
            end else begin
                w_diff = w_a21 - w_t21;
                if (w_diff > STEP21) w_new = w_dn[SERVO_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_bnd) r_active <= w_new;
            if (!i_run)     r_pwm <= 1'b0;
            else if (i_bnd) r_pwm <= (w_new != '0);
            else            r_pwm <= (w_cnt_inc < w_a21);
        end
    end

    assign o_active = r_active;
    assign o_pwm    = r_pwm;

endmodule

// File: rtl/servo_pwm_driver.sv
// Three-channel servo pulse generator sharing one frame counter.
// X/Y are slew-limited per frame; fire snaps to its target.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD,
    parameter int SLEW_STEP     = DEF_SLEW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [SERVO_W-1:0] x_value,
    input  logic [SERVO_W-1:0] y_value,
    input  logic [SERVO_W-1:0] fire_value,
    output logic               x_pwm,
    output logic               y_pwm,
    output logic               fire_pwm,
    output logic               frame_tick,
    output logic [SERVO_W-1:0] x_active,
    output logic [SERVO_W-1:0] y_active,
    output logic [SERVO_W-1:0] fire_active
);

    localparam logic [SERVO_W-1:0] LAST = SERVO_W'(PERIOD_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SERVO_W-1:0] r_cnt;
    logic [SERVO_W-1:0] w_cnt_nxt;
    logic               r_primed;
    logic               r_tick;
    logic               w_bnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_primed <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_primed <= r_primed | w_bnd;
            r_tick   <= w_bnd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_bnd       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_bnd       = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == LAST) begin
                    w_bnd = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    servo_slew_ch #(
        .PERIOD_CYCLES(PERIOD_CYCLES),
        .SLEW_STEP    (SLEW_STEP)
    ) u_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bnd    (w_bnd),
        .i_run    (en),
        .i_target (x_value),
        .i_primed (r_primed),
        .i_slew_en(1'b1),
        .i_cnt    (r_cnt),
        .o_active (x_active),
        .o_pwm    (x_pwm)
    );

    servo_slew_ch #(
        .PERIOD_CYCLES(PERIOD_CYCLES),
        .SLEW_STEP    (SLEW_STEP)
    ) u_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bnd    (w_bnd),
        .i_run    (en),
        .i_target (y_value),
        .i_primed (r_primed),
        .i_slew_en(1'b1),
        .i_cnt    (r_cnt),
        .o_active (y_active),
        .o_pwm    (y_pwm)
    );

    servo_slew_ch #(
        .PERIOD_CYCLES(PERIOD_CYCLES),
        .SLEW_STEP    (SLEW_STEP)
    ) u_fire (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bnd    (w_bnd),
        .i_run    (en),
        .i_target (fire_value),
        .i_primed (r_primed),
        .i_slew_en(1'b0),
        .i_cnt    (r_cnt),
        .o_active (fire_active),
        .o_pwm    (fire_pwm)
    );

    assign frame_tick = r_tick;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver with a 1000-cycle frame and slew 100.
// Each task drives one scenario and checks hand-computed values inline.
module tb_servo_pwm_driver;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [19:0] x_value;
    logic [19:0] y_value;
    logic [19:0] fire_value;
    logic        x_pwm;
    logic        y_pwm;
    logic        fire_pwm;
    logic        frame_tick;
    logic [19:0] x_active;
    logic [19:0] y_active;
    logic [19:0] fire_active;

    int vecs = 0;
    int errs = 0;

    servo_pwm_driver #(
        .PERIOD_CYCLES(1000),
        .SLEW_STEP    (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .x_value    (x_value),
        .y_value    (y_value),
        .fire_value (fire_value),
        .x_pwm      (x_pwm),
        .y_pwm      (y_pwm),
        .fire_pwm   (fire_pwm),
        .frame_tick (frame_tick),
        .x_active   (x_active),
        .y_active   (y_active),
        .fire_active(fire_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        x_value = '0;
        y_value = '0;
        fire_value = '0;
        step();
        step();
        vecs++;
        if ({x_pwm, y_pwm, fire_pwm, frame_tick} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_bits got %b want 0000",
                     {x_pwm, y_pwm, fire_pwm, frame_tick});
        end
        vecs++;
        if ({x_active, y_active, fire_active} !== 60'd0) begin
            errs++;
            $display("FAIL reset_active got %0d/%0d/%0d want 0/0/0",
                     x_active, y_active, fire_active);
        end
        rst_n = 1'b1;
        step();
        vecs++;
        if ({x_pwm, frame_tick} !== 2'b00) begin
            errs++;
            $display("FAIL idle_bits got %b want 00", {x_pwm, frame_tick});
        end
    endtask

    task automatic test_enable();
        int xh;
        int ybad;
        int ticks;
        x_value = 20'd300;
        en = 1'b1;
        step();
        vecs++;
        if (frame_tick !== 1'b1 || x_active !== 20'd300 || x_pwm !== 1'b1) begin
            errs++;
            $display("FAIL en_first got tick=%b xa=%0d xp=%b want 1/300/1",
                     frame_tick, x_active, x_pwm);
        end
        xh = 1;
        ybad = 0;
        ticks = 0;
        for (int i = 1; i < 1000; i++) begin
            step();
            if (x_pwm) xh++;
            if (y_pwm || fire_pwm) ybad++;
            if (frame_tick) ticks++;
        end
        vecs++;
        if (xh != 300) begin
            errs++;
            $display("FAIL en_x_width got %0d want 300", xh);
        end
        vecs++;
        if (ybad != 0 || ticks != 0) begin
            errs++;
            $display("FAIL en_quiet got yf=%0d ticks=%0d want 0/0", ybad, ticks);
        end
        step();
        vecs++;
        if (frame_tick !== 1'b1 || x_active !== 20'd300) begin
            errs++;
            $display("FAIL en_period got tick=%b xa=%0d want 1/300",
                     frame_tick, x_active);
        end
    endtask

    task automatic test_slew();
        bit ok;
        logic [19:0] exp_x [4];
        exp_x = '{20'd400, 20'd500, 20'd600, 20'd650};
        x_value = 20'd650;
        fire_value = 20'd500;
        for (int f = 0; f < 4; f++) begin
            wait_tick(ok);
            vecs++;
            if (!ok || x_active !== exp_x[f]) begin
                errs++;
                $display("FAIL slew_x%0d got %0d ok=%0d want %0d",
                         f, x_active, ok, exp_x[f]);
            end
            if (f == 0) begin
                vecs++;
                if (fire_active !== 20'd500) begin
                    errs++;
                    $display("FAIL slew_fire got %0d want 500", fire_active);
                end
            end
        end
    endtask

    task automatic test_midframe();
        bit ok;
        int yh;
        y_value = 20'd200;
        wait_tick(ok);
        wait_tick(ok);
        vecs++;
        if (!ok || y_active !== 20'd200) begin
            errs++;
            $display("FAIL mid_pre got %0d want 200", y_active);
        end
        yh = y_pwm ? 1 : 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (y_pwm) yh++;
        end
        y_value = 20'd800;
        for (int i = 0; i < 499; i++) begin
            step();
            if (y_pwm) yh++;
        end
        vecs++;
        if (yh != 200 || y_active !== 20'd200) begin
            errs++;
            $display("FAIL mid_keep got w=%0d ya=%0d want 200/200", yh, y_active);
        end
        step();
        vecs++;
        if (frame_tick !== 1'b1 || y_active !== 20'd300) begin
            errs++;
            $display("FAIL mid_next got tick=%b ya=%0d want 1/300",
                     frame_tick, y_active);
        end
    endtask

    task automatic test_clamp();
        int fh;
        for (int i = 0; i < 999; i++) step();
        fire_value = 20'd1_000_000;
        step();
        vecs++;
        if (frame_tick !== 1'b1 || fire_active !== 20'd1000) begin
            errs++;
            $display("FAIL clamp_act got tick=%b fa=%0d want 1/1000",
                     frame_tick, fire_active);
        end
        fh = fire_pwm ? 1 : 0;
        for (int i = 1; i < 1000; i++) begin
            step();
            if (fire_pwm) fh++;
        end
        vecs++;
        if (fh != 1000) begin
            errs++;
            $display("FAIL clamp_high got %0d want 1000", fh);
        end
        step();
        vecs++;
        if (frame_tick !== 1'b1 || fire_pwm !== 1'b1) begin
            errs++;
            $display("FAIL clamp_wrap got tick=%b fp=%b want 1/1",
                     frame_tick, fire_pwm);
        end
    endtask

    task automatic test_en_drop();
        bit ok;
        logic [19:0] exp_x [4];
        exp_x = '{20'd550, 20'd450, 20'd350, 20'd300};
        x_value = 20'd300;
        fire_value = 20'd0;
        for (int f = 0; f < 4; f++) begin
            wait_tick(ok);
            vecs++;
            if (!ok || x_active !== exp_x[f]) begin
                errs++;
                $display("FAIL down_x%0d got %0d want %0d", f, x_active, exp_x[f]);
            end
        end
        for (int i = 0; i < 150; i++) step();
        vecs++;
        if (x_pwm !== 1'b1 || fire_pwm !== 1'b0) begin
            errs++;
            $display("FAIL drop_pre got xp=%b fp=%b want 1/0", x_pwm, fire_pwm);
        end
        en = 1'b0;
        x_value = 20'd650;
        step();
        vecs++;
        if ({x_pwm, y_pwm, fire_pwm, frame_tick} !== 4'b0000
            || x_active !== 20'd300) begin
            errs++;
            $display("FAIL drop_idle got bits=%b xa=%0d want 0000/300",
                     {x_pwm, y_pwm, fire_pwm, frame_tick}, x_active);
        end
        en = 1'b1;
        step();
        vecs++;
        if (frame_tick !== 1'b1 || x_active !== 20'd400 || x_pwm !== 1'b1) begin
            errs++;
            $display("FAIL drop_resume got tick=%b xa=%0d xp=%b want 1/400/1",
                     frame_tick, x_active, x_pwm);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 100; i++) step();
        vecs++;
        if (x_pwm !== 1'b1) begin
            errs++;
            $display("FAIL rst_pre got xp=%b want 1", x_pwm);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({x_pwm, y_pwm, fire_pwm, frame_tick} !== 4'b0000
            || {x_active, y_active, fire_active} !== 60'd0) begin
            errs++;
            $display("FAIL rst_async got bits=%b xa=%0d ya=%0d fa=%0d want 0",
                     {x_pwm, y_pwm, fire_pwm, frame_tick},
                     x_active, y_active, fire_active);
        end
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        en = 1'b1;
        step();
        vecs++;
        if (frame_tick !== 1'b1 || x_active !== 20'd650 || y_active !== 20'd800) begin
            errs++;
            $display("FAIL rst_direct got tick=%b xa=%0d ya=%0d want 1/650/800",
                     frame_tick, x_active, y_active);
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_slew();
        test_midframe();
        test_clamp();
        test_en_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
